ysyx_23060278_mdu: RTL

//  Multi-cycle RV32M multiply/divide unit. Sits directly downstream of the decoder
//  and handles instructions flagged md_en. md_op is func3.

---
 rtl/ysyx_23060278_mdu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060278_mdu.sv
// ysyx_23060278_mdu: multi-cycle RV32M multiply/divide unit.
// Holds one operation at a time. Both sides use a valid/ready handshake.
// Iterative radix-2 shift-add multiply and restoring divide both run on
// operand magnitudes. The sign is applied on the edge that enters DONE.
// Divide-by-zero and signed overflow are resolved at accept without iterating.
// Optional feature macro: YSYX_23060278_MDU_FAST_MUL_EN
//   When defined, every MUL* op uses a single-cycle multiply and goes straight
//   to DONE. When undefined, MUL* ops use the iterative shift-add path.
module ysyx_23060278_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two's-complement negate when neg is set (XLEN-wide)
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    // Two's-complement negate when neg is set (2*XLEN-wide)
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? ('0 - v) : v;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_r;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;

    logic              is_div;
    logic              sgn1;
    logic              sgn2;
    logic              n1;
    logic              n2;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;
    logic              accept;

`ifdef YSYX_23060278_MDU_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa;
    logic signed [2*XLEN-1:0] fb;
    logic signed [2*XLEN-1:0] fp;
    logic        [XLEN-1:0]   fast_res;

    // Single-cycle product of sign/zero-extended operands
    always_comb begin
        fa       = $signed({{XLEN{sgn1 & src1[XLEN-1]}}, src1});
        fb       = $signed({{XLEN{sgn2 & src2[XLEN-1]}}, src2});
        fp       = fa * fb;
        fast_res = (md_op[1:0] == 2'b00) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
    end
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && in_valid && !flush;

    // Operand decode at accept: signedness, magnitudes and divide special cases
    always_comb begin
        is_div      = md_op[2];
        sgn1        = is_div ? ~md_op[0] : (md_op[1:0] == 2'b01 || md_op[1:0] == 2'b10);
        sgn2        = is_div ? ~md_op[0] : (md_op[1:0] == 2'b01);
        n1          = sgn1 & src1[XLEN-1];
        n2          = sgn2 & src2[XLEN-1];
        mag1        = neg_x(src1, n1);
        mag2        = neg_x(src2, n2);
        div_zero    = (src2 == '0);
        div_ovf     = ~md_op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
        special_res = '0;
        if (div_zero)
            special_res = md_op[1] ? src1 : '1;
        else if (div_ovf)
            special_res = md_op[1] ? '0 : src1;
    end

    // One iteration step of shift-add multiply and restoring divide, plus final sign fix
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
        if (div_trial[XLEN])
            div_next = {acc[2*XLEN-2:0], 1'b0};
        else
            div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        prod_fix  = neg_2x(mul_next, neg_q);
        mul_res   = (op_r[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_res   = op_r[1] ? neg_x(div_next[2*XLEN-1:XLEN], neg_r)
                            : neg_x(div_next[XLEN-1:0], neg_q);
    end

    // Control: state, countdown, captured op/sign flags and the held result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
            op_r   <= 3'b000;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r  <= md_op;
                        neg_q <= n1 ^ n2;
                        neg_r <= n1;
                        if (is_div && (div_zero || div_ovf)) begin
                            state  <= S_DONE;
                            result <= special_res;
                        end
`ifdef YSYX_23060278_MDU_FAST_MUL_EN
                        else if (!is_div) begin
                            state  <= S_DONE;
                            result <= fast_res;
                        end
`endif
                        else begin
                            state <= is_div ? S_DIV : S_MUL;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        result <= mul_res;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DIV: begin
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        result <= div_res;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath: magnitudes loaded at accept, one shift/subtract step per busy cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            acc  <= is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            opnd <= is_div ? mag2 : mag1;
        end else if (state == S_MUL) begin
            acc <= mul_next;
        end else if (state == S_DIV) begin
            acc <= div_next;
        end
    end

endmodule
